// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM state encoding and baud-rate constants.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam int UART_DIV_9600 = 1250;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered full/empty flags and a one-cycle overflow pulse
// for writes dropped while full.
module sync_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push, pop;

  // A write while full is dropped even if a pop frees a slot in the same cycle.
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count_q  <= count_d;
      full     <= (count_d == CNT_FULL);
      empty    <= (count_d == '0);
      overflow <= wr_en && full;
    end
  end

  // NOTE: storage has no reset; the flushed pointers and count make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a sync_fifo: start bit, DATA_W data bits LSB first,
// optional even parity (UART_TX_PARITY_EN), then STOP_BITS stop bits.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int CLK_DIV    = UART_DIV_9600,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic              i_CLK,
  input  logic              i_RST_N,
  input  logic [DATA_W-1:0] i_DATA,
  input  logic              i_WR_EN,
  output logic              o_FULL,
  output logic              o_EMPTY,
  output logic              o_BUSY,
  output logic              o_OVERFLOW,
  output logic              o_TXD
);

  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam int BIT_W  = $clog2(DATA_W) + 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  tx_state_e         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              txd_q, txd_d;
  logic              bit_end, start_frame, pop;
  logic [DATA_W-1:0] fifo_data;
`ifdef UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (i_CLK),
    .rst_n    (i_RST_N),
    .wr_en    (i_WR_EN),
    .wr_data  (i_DATA),
    .rd_en    (pop),
    .rd_data  (fifo_data),
    .full     (o_FULL),
    .empty    (o_EMPTY),
    .overflow (o_OVERFLOW)
  );

  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d     = state_q;
    baud_d      = bit_end ? '0 : baud_q + 1'b1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    txd_d       = txd_q;
    start_frame = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        baud_d      = '0;
        start_frame = !o_EMPTY;
      end
      ST_START: if (bit_end) begin
        txd_d   = shift_q[0];
        shift_d = shift_q >> 1;
        bit_d   = '0;
        state_d = ST_DATA;
      end
      ST_DATA: if (bit_end) begin
        if (bit_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
          txd_d   = parity_q;
          state_d = ST_PARITY;
`else
          txd_d   = 1'b1;
          bit_d   = '0;
          state_d = ST_STOP;
`endif
        end else begin
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (bit_end) begin
        txd_d   = 1'b1;
        bit_d   = '0;
        state_d = ST_STOP;
      end
`endif
      ST_STOP: if (bit_end) begin
        if (bit_q == STOP_LAST) begin
          // Chain straight into the next start bit when a word is waiting.
          start_frame = !o_EMPTY;
          state_d     = ST_IDLE;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    if (start_frame) begin
      shift_d = fifo_data;
      txd_d   = 1'b0;
      baud_d  = '0;
      state_d = ST_START;
`ifdef UART_TX_PARITY_EN
      parity_d = ^fifo_data;
`endif
    end
  end

  assign pop = start_frame;

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign o_TXD  = txd_q;
  assign o_BUSY = (state_q != ST_IDLE);

endmodule
